// File: rtl/game_ctrl.sv
// game_ctrl: game-state controller sitting directly behind the bird position stage.
// It watches the bird bounding box against the current pipe and the floor,
// counts pipes passed and sequences the game through IDLE, PLAY, HIT and OVER.
// It also drives the bird stage reset and the run enable for frame-rate movement.
// Optional build macro GAME_CTRL_HISCORE_EN adds a best-score register and port.

module game_ctrl #(
    parameter int N        = 10,
    parameter int SW       = 8,
    parameter int PIPE_W   = 40,
    parameter int FLOOR_Y  = 479,
    parameter int HIT_HOLD = 60
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic          start,
    input  logic [N-1:0]  x0,
    input  logic [N-1:0]  y0,
    input  logic [N-1:0]  x1,
    input  logic [N-1:0]  y1,
    input  logic [N-1:0]  pipe_x,
    input  logic [N-1:0]  gap_top,
    input  logic [N-1:0]  gap_bot,
    output logic          bird_rst,
    output logic          run,
    output logic          game_over,
    output logic          hit,
`ifdef GAME_CTRL_HISCORE_EN
    output logic [SW-1:0] score,
    output logic [SW-1:0] hiscore
`else
    output logic [SW-1:0] score
`endif
);

    // Hold counter only needs to reach HIT_HOLD-1.
    localparam int HW = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;

    localparam logic [N:0]    PIPE_W_X  = (N+1)'(PIPE_W);
    localparam logic [N-1:0]  FLOOR_LIM = N'(FLOOR_Y);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HIT_HOLD - 1);
    localparam logic [SW-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_HIT,
        ST_OVER
    } state_t;

    state_t        state_q,     state_d;
    logic [SW-1:0] score_q,     score_d;
    logic          scored_q,    scored_d;
    logic [HW-1:0] hold_q,      hold_d;
    logic [N-1:0]  pipeXPrev_q, pipeXPrev_d;
    logic          hit_q,       hit_d;
    logic          birdRst_q,   birdRst_d;
    logic          run_q,       run_d;
    logic          gameOver_q,  gameOver_d;
`ifdef GAME_CTRL_HISCORE_EN
    logic [SW-1:0] hiscore_q,   hiscore_d;
`endif

    // Pipe extents are formed one bit wider than the coordinates so a pipe
    // near the right edge of the coordinate space never wraps around.
    logic [N:0] pipeRight;
    logic [N:0] pipeEnd;
    logic       colX;
    logic       colY;
    logic       floorHit;
    logic       coll;

    // Collision term: bird overlaps the pipe columns outside the open gap,
    // or the bird has reached the floor.
    always_comb begin
        pipeEnd   = {1'b0, pipe_x} + PIPE_W_X;
        pipeRight = pipeEnd - (N+1)'(1);
        colX      = (x1 >= pipe_x) && ({1'b0, x0} <= pipeRight);
        colY      = (y0 < gap_top) || (y1 > gap_bot);
        floorHit  = (y1 >= FLOOR_LIM);
        coll      = (colX && colY) || floorHit;
    end

    // Next-state logic for the game sequencer, scoring and hold timer.
    // Scoring runs independently of the collision check, so a frame that
    // both scores and collides still bumps the score before HIT is entered.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        scored_d    = scored_q;
        hold_d      = hold_q;
        pipeXPrev_d = frame_tick ? pipe_x : pipeXPrev_q;
        hit_d       = (state_q == ST_PLAY) && coll;

        case (state_q)
            ST_IDLE: begin
                if (start && frame_tick) begin
                    state_d  = ST_PLAY;
                    score_d  = '0;
                    scored_d = 1'b0;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    // A pipe that moved right has respawned; that clear takes
                    // priority over any score on the same tick.
                    if (pipe_x > pipeXPrev_q) begin
                        scored_d = 1'b0;
                    end else if (!scored_q && (pipeEnd <= {1'b0, x0})) begin
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + SW'(1);
                        end
                        scored_d = 1'b1;
                    end
                end
                // Only the registered hit ends the game, so even a one-cycle
                // collision pulse is caught.
                if (hit_q) begin
                    state_d = ST_HIT;
                    hold_d  = '0;
                end
            end
            ST_HIT: begin
                if (frame_tick) begin
                    hold_d = hold_q + HW'(1);
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_OVER;
                    end
                end
            end
            ST_OVER: begin
                if (start && frame_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Moore outputs are decoded from the state being registered, so the
        // output flops always agree with the state flop.
        birdRst_d  = (state_d == ST_IDLE);
        run_d      = (state_d == ST_PLAY);
        gameOver_d = (state_d == ST_OVER);
    end

`ifdef GAME_CTRL_HISCORE_EN
    // Best score is captured on every entry to OVER and survives new games.
    always_comb begin
        hiscore_d = hiscore_q;
        if ((state_d == ST_OVER) && (state_q != ST_OVER) && (score_q > hiscore_q)) begin
            hiscore_d = score_q;
        end
    end
`endif

    // Single register stage for the whole controller with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            score_q     <= '0;
            scored_q    <= 1'b0;
            hold_q      <= '0;
            pipeXPrev_q <= '0;
            hit_q       <= 1'b0;
            birdRst_q   <= 1'b1;
            run_q       <= 1'b0;
            gameOver_q  <= 1'b0;
`ifdef GAME_CTRL_HISCORE_EN
            hiscore_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            scored_q    <= scored_d;
            hold_q      <= hold_d;
            pipeXPrev_q <= pipeXPrev_d;
            hit_q       <= hit_d;
            birdRst_q   <= birdRst_d;
            run_q       <= run_d;
            gameOver_q  <= gameOver_d;
`ifdef GAME_CTRL_HISCORE_EN
            hiscore_q   <= hiscore_d;
`endif
        end
    end

    assign bird_rst  = birdRst_q;
    assign run       = run_q;
    assign game_over = gameOver_q;
    assign hit       = hit_q;
    assign score     = score_q;
`ifdef GAME_CTRL_HISCORE_EN
    assign hiscore   = hiscore_q;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed bench for game_ctrl with hand-computed expectations.
// Walks reset, pipe scoring, pipe and floor collisions, the HIT hold, restart,
// mid-game reset, respawn priority and score saturation.

module tb_game_ctrl;

    localparam int N  = 10;
    localparam int SW = 8;

    logic          clk;
    logic          reset;
    logic          frame_tick;
    logic          start;
    logic [N-1:0]  x0, y0, x1, y1;
    logic [N-1:0]  pipe_x, gap_top, gap_bot;
    logic          bird_rst, run, game_over, hit;
    logic [SW-1:0] score;
`ifdef GAME_CTRL_HISCORE_EN
    logic [SW-1:0] hiscore;
`endif

    int checkCount;
    int failCount;

    game_ctrl #(
        .N(N), .SW(SW), .PIPE_W(40), .FLOOR_Y(479), .HIT_HOLD(60)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .start(start),
        .x0(x0),
        .y0(y0),
        .x1(x1),
        .y1(y1),
        .pipe_x(pipe_x),
        .gap_top(gap_top),
        .gap_bot(gap_bot),
        .bird_rst(bird_rst),
        .run(run),
        .game_over(game_over),
        .hit(hit),
`ifdef GAME_CTRL_HISCORE_EN
        .score(score),
        .hiscore(hiscore)
`else
        .score(score)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // One frame: frame_tick high for exactly one rising edge, start as given.
    // Called and returns on a falling edge.
    task automatic applyStimulus(input logic startVal);
        start      = startVal;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        start      = 1'b0;
        @(negedge clk);
    endtask

    // Respawn the pipe far right, then drop it just past the bird to score.
    task automatic scoreOnePipe();
        pipe_x = 10'd600;
        applyStimulus(1'b0);
        pipe_x = 10'd120;
        applyStimulus(1'b0);
    endtask

    // Ride out the HIT freeze one frame at a time.
    task automatic holdFrames(input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b0);
        end
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        reset      = 1'b0;
        frame_tick = 1'b0;
        start      = 1'b0;
        x0 = 10'd160; x1 = 10'd160; y0 = 10'd232; y1 = 10'd247;
        pipe_x = 10'd300; gap_top = 10'd200; gap_bot = 10'd300;

        // Reset held for two cycles, then released.
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_bird_rst", 32'(bird_rst), 32'd1);
        checkOutput("rst_run", 32'(run), 32'd0);
        checkOutput("rst_score", 32'(score), 32'd0);
        checkOutput("rst_game_over", 32'(game_over), 32'd0);
        checkOutput("rst_hit", 32'(hit), 32'd0);
`ifdef GAME_CTRL_HISCORE_EN
        checkOutput("rst_hiscore", 32'(hiscore), 32'd0);
`endif

        // Game 1: start, walk the pipe across the bird.
        applyStimulus(1'b1);
        checkOutput("g1_run", 32'(run), 32'd1);
        checkOutput("g1_bird_rst", 32'(bird_rst), 32'd0);
        checkOutput("g1_hit0", 32'(hit), 32'd0);
        for (int p = 299; p >= 121; p--) begin
            pipe_x = 10'(p);
            applyStimulus(1'b0);
        end
        checkOutput("g1_score_before", 32'(score), 32'd0);
        pipe_x = 10'd120;
        applyStimulus(1'b0);
        checkOutput("g1_score_first", 32'(score), 32'd1);
        for (int p = 119; p >= 115; p--) begin
            pipe_x = 10'(p);
            applyStimulus(p == 117);
        end
        checkOutput("g1_score_once", 32'(score), 32'd1);
        checkOutput("g1_start_ignored", 32'(run), 32'd1);
        checkOutput("g1_no_hit", 32'(hit), 32'd0);
        pipe_x = 10'd600;
        applyStimulus(1'b0);
        pipe_x = 10'd130;
        applyStimulus(1'b0);
        pipe_x = 10'd121;
        applyStimulus(1'b0);
        checkOutput("g1_score_pre2", 32'(score), 32'd1);
        pipe_x = 10'd120;
        applyStimulus(1'b0);
        checkOutput("g1_score_second", 32'(score), 32'd2);

        // Pipe collision above the gap.
        pipe_x  = 10'd150;
        gap_top = 10'd240;
        @(negedge clk);
        checkOutput("g1_hit", 32'(hit), 32'd1);
        checkOutput("g1_run_still", 32'(run), 32'd1);
        @(negedge clk);
        checkOutput("g1_hit_run", 32'(run), 32'd0);
        checkOutput("g1_hit_bird_rst", 32'(bird_rst), 32'd0);
        holdFrames(59);
        checkOutput("g1_hold59", 32'(game_over), 32'd0);
        holdFrames(1);
        checkOutput("g1_over", 32'(game_over), 32'd1);
        checkOutput("g1_over_run", 32'(run), 32'd0);
        checkOutput("g1_over_score", 32'(score), 32'd2);
`ifdef GAME_CTRL_HISCORE_EN
        checkOutput("g1_hiscore", 32'(hiscore), 32'd2);
`endif

        // Restart: OVER -> IDLE keeps the score until PLAY.
        applyStimulus(1'b1);
        checkOutput("g2_idle_bird_rst", 32'(bird_rst), 32'd1);
        checkOutput("g2_idle_game_over", 32'(game_over), 32'd0);
        checkOutput("g2_idle_score", 32'(score), 32'd2);
        pipe_x  = 10'd600;
        gap_top = 10'd200;
        applyStimulus(1'b1);
        checkOutput("g2_play_score", 32'(score), 32'd0);
        checkOutput("g2_play_run", 32'(run), 32'd1);
        for (int i = 0; i < 3; i++) scoreOnePipe();
        checkOutput("g2_score3", 32'(score), 32'd3);

        // Floor collision with no pipe overlap.
        pipe_x = 10'd600;
        y0 = 10'd464;
        y1 = 10'd479;
        @(negedge clk);
        checkOutput("g2_floor_hit", 32'(hit), 32'd1);
        @(negedge clk);
        checkOutput("g2_floor_run", 32'(run), 32'd0);
        y0 = 10'd232;
        y1 = 10'd247;
        holdFrames(60);
        checkOutput("g2_over", 32'(game_over), 32'd1);
`ifdef GAME_CTRL_HISCORE_EN
        checkOutput("g2_hiscore", 32'(hiscore), 32'd3);
`endif

        // Game 3: ends at 2 through a one-cycle collision pulse.
        applyStimulus(1'b1);
        checkOutput("g3_idle_score", 32'(score), 32'd3);
        applyStimulus(1'b1);
        for (int i = 0; i < 2; i++) scoreOnePipe();
        checkOutput("g3_score2", 32'(score), 32'd2);
        pipe_x  = 10'd150;
        gap_top = 10'd240;
        @(negedge clk);
        checkOutput("g3_pulse_hit", 32'(hit), 32'd1);
        pipe_x  = 10'd120;
        gap_top = 10'd200;
        @(negedge clk);
        checkOutput("g3_pulse_run", 32'(run), 32'd0);
        checkOutput("g3_pulse_hit_clr", 32'(hit), 32'd0);
        holdFrames(60);
        checkOutput("g3_over", 32'(game_over), 32'd1);
        checkOutput("g3_over_score", 32'(score), 32'd2);
`ifdef GAME_CTRL_HISCORE_EN
        checkOutput("g3_hiscore_kept", 32'(hiscore), 32'd3);
`endif

        // Game 4: reset in the middle of play.
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        for (int i = 0; i < 5; i++) scoreOnePipe();
        checkOutput("g4_score5", 32'(score), 32'd5);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("g4_rst_score", 32'(score), 32'd0);
        checkOutput("g4_rst_bird_rst", 32'(bird_rst), 32'd1);
        checkOutput("g4_rst_run", 32'(run), 32'd0);
`ifdef GAME_CTRL_HISCORE_EN
        checkOutput("g4_rst_hiscore", 32'(hiscore), 32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Game 5: respawn beats score on the same tick, then saturation.
        pipe_x = 10'd100;
        applyStimulus(1'b1);
        checkOutput("g5_run", 32'(run), 32'd1);
        pipe_x = 10'd110;
        applyStimulus(1'b0);
        checkOutput("g5_respawn_wins", 32'(score), 32'd0);
        applyStimulus(1'b0);
        checkOutput("g5_score_after", 32'(score), 32'd1);
        for (int i = 0; i < 254; i++) scoreOnePipe();
        checkOutput("g5_score_max", 32'(score), 32'd255);
        scoreOnePipe();
        checkOutput("g5_score_sat", 32'(score), 32'd255);
        checkOutput("g5_no_hit", 32'(hit), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Game-state controller directly downstream of the bird position stage.
- Consumes the bird bounding box and the current pipe's position and gap, and detects collisions with the pipe or the floor.
- Counts pipes passed and sequences the game through IDLE/PLAY/HIT/OVER.
- Drives the bird stage's reset and the enable for the frame-rate movement logic.

Parameters:
- N, 10, coordinate width (shared with the bird stage).
- SW, 8, score width; score saturates at 2^SW-1.
- PIPE_W, 40, pipe width in pixels.
- FLOOR_Y, 479, lowest legal bird y1; y1 >= FLOOR_Y is a floor hit.
- HIT_HOLD, 60, frames to freeze in HIT before entering OVER.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (asserted when 0)
- frame_tick  input  1  one-cycle pulse per video frame; all game-time steps occur on it
- start  input  1  level, player start/flap key (already synchronised)
- x0, y0, x1, y1  input  N each  bird bounding box, inclusive (x0<=x1, y0<=y1)
- pipe_x  input  N  pipe left edge; decreases over time, jumps up when the pipe respawns
- gap_top, gap_bot  input  N  inclusive open-gap rows of the pipe
- bird_rst  output  1  high = hold bird stage at start position
- run  output  1  high = bird/pipe stages may advance on frame_tick
- game_over  output  1  high in OVER
- hit  output  1  registered collision flag
- score  output  SW  pipes passed in the current game

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=IDLE, bird_rst=1, run=0, game_over=0, hit=0, score=0.
  - scored flag=0, hold counter=0, pipe_x_prev=0.
  - Reset overrides everything, including mid-game.
- Collision term (combinational, evaluated every cycle):
  - col_x = (x1 >= pipe_x) && (x0 <= pipe_x+PIPE_W-1).
  - col_y = (y0 < gap_top) || (y1 > gap_bot).
  - floor = (y1 >= FLOOR_Y).
  - coll = (col_x && col_y) || floor.
  - pipe_x+PIPE_W is computed at N+1 bits; no wrap.
- hit register:
  - hit <= coll on every cycle in PLAY; 0 in all other states.
  - Latency is 1 cycle from input change to hit.
- States:
  - IDLE:
    - bird_rst=1, run=0.
    - start==1 on a cycle with frame_tick -> PLAY, with score cleared and the scored flag cleared.
  - PLAY:
    - bird_rst=0, run=1.
    - hit==1 -> HIT; hold counter cleared.
    - Collision is acted on only through the registered hit, so a transient one-cycle coll still ends the game.
  - HIT:
    - run=0, bird_rst=0; the bird is frozen visibly.
    - Hold counter increments on frame_tick.
    - When the counter equals HIT_HOLD-1 and frame_tick is high -> OVER.
  - OVER:
    - game_over=1, run=0, bird_rst=0.
    - start==1 with frame_tick -> IDLE.
    - The score is retained until the next IDLE->PLAY.
- Scoring (PLAY only, on frame_tick):
  - If !scored and pipe_x+PIPE_W <= x0: score<=score+1 (held at max when saturated), scored<=1.
  - Respawn detection: if pipe_x > pipe_x_prev then scored<=0.
  - pipe_x_prev is updated on every frame_tick.
  - A respawn and a score on the same tick: the respawn clear wins; no increment.
- Simultaneous events:
  - A collision and a score on the same frame: the score increments, then the FSM goes to HIT.
  - start is ignored in PLAY and HIT.
- Outputs bird_rst, run and game_over are decoded from the registered state (Moore); no combinational path from inputs.

Optional Feature:
- Macro: GAME_CTRL_HISCORE_EN.
- When defined:
  - Adds output hiscore [SW-1:0], reset to 0.
  - On every entry to OVER, hiscore <= max(hiscore, score).
  - hiscore survives IDLE/PLAY cycles and is cleared only by reset.
- When not defined: no hiscore port or register; all other behaviour is identical.

Test Plan:
1. Hold reset=0 for 2 cycles, then release -> state IDLE, bird_rst=1, run=0, score=0, game_over=0.
2. start=1 with frame_tick; bird box (160,232)-(160,247); pipe_x=300, gap 200..300 -> PLAY, run=1, bird_rst=0, hit stays 0.
3. Step pipe_x down by 1 per frame_tick from 300 until pipe_x+40 <= 160 (pipe_x=120) -> score goes 0->1 exactly once. pipe_x jumps to 600 -> scored clears. Repeat -> score=2.
4. pipe_x=150, gap 240..300, bird y0=232 -> hit=1 one cycle after the inputs settle. FSM -> HIT, run=0. After 60 frame_ticks -> OVER, game_over=1.
5. Bird y1 driven to 479 with no pipe overlap (pipe_x=600) -> floor hit -> HIT. Then start+frame_tick in OVER -> IDLE, bird_rst=1, score retained until the next start.
6. reset=0 asserted mid-PLAY with score=5 -> the next cycle is IDLE with score=0. With GAME_CTRL_HISCORE_EN defined: hiscore reads 3 after a game ending at 3, and stays 3 after a later game ending at 2.
